// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, branch condition encodings and data width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned FLAG_W    = 5;
  localparam int unsigned COND_W    = 3;

  localparam int unsigned FLG_S  = 4;
  localparam int unsigned FLG_Z  = 3;
  localparam int unsigned FLG_P  = 2;
  localparam int unsigned FLG_C  = 1;
  localparam int unsigned FLG_OV = 0;

  localparam logic [COND_W-1:0] COND_ALWAYS = 3'd0;
  localparam logic [COND_W-1:0] COND_Z      = 3'd1;
  localparam logic [COND_W-1:0] COND_NZ     = 3'd2;
  localparam logic [COND_W-1:0] COND_S      = 3'd3;
  localparam logic [COND_W-1:0] COND_NS     = 3'd4;
  localparam logic [COND_W-1:0] COND_C      = 3'd5;
  localparam logic [COND_W-1:0] COND_OV     = 3'd6;
  localparam logic [COND_W-1:0] COND_P      = 3'd7;

  typedef struct packed {
    logic s;
    logic z;
    logic p;
    logic cout;
    logic ov;
  } alu_flags_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Maps a status word and condition select to a branch-taken bit; shared with the branch unit.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [4:0] psw,
  input  logic [2:0] cond_sel,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      COND_ALWAYS: cond_true = 1'b1;
      COND_Z:      cond_true = psw[FLG_Z];
      COND_NZ:     cond_true = ~psw[FLG_Z];
      COND_S:      cond_true = psw[FLG_S];
      COND_NS:     cond_true = ~psw[FLG_S];
      COND_C:      cond_true = psw[FLG_C];
      COND_OV:     cond_true = psw[FLG_OV];
      COND_P:      cond_true = psw[FLG_P];
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Result FIFO behind the ALU: buffers {C, flags}, tracks the last accepted flags (psw)
// and a sticky overflow, and evaluates branch conditions on psw.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_c,
  input  logic [4:0]             in_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_c,
  output logic [4:0]             out_flags,
  output logic [4:0]             psw,
  output logic                   ov_sticky,
  input  logic                   clr_sticky,
  input  logic [2:0]             cond_sel,
  output logic                   cond_true,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = WIDTH + FLAG_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       psw_q, psw_d;
  logic             ov_sticky_q, ov_sticky_d;

  logic full, empty, push, pop;
  logic [ENTRY_W-1:0] head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid & ~full;
  assign pop   = out_ready & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    psw_d       = psw_q;
    ov_sticky_d = ov_sticky_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      psw_d    = in_flags;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Set has priority over clear.
    if (push && in_flags[FLG_OV]) begin
      ov_sticky_d = 1'b1;
    end else if (clr_sticky) begin
      ov_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      psw_q       <= '0;
      ov_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      psw_q       <= psw_d;
      ov_sticky_q <= ov_sticky_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_c, in_flags};
    end
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_c     = head[ENTRY_W-1:FLAG_W];
  assign out_flags = head[FLAG_W-1:0];
  assign psw       = psw_q;
  assign ov_sticky = ov_sticky_q;
  assign count     = count_q;

  alu_cond_eval u_cond_eval (
    .psw       (psw_q),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed sequences, a condition table and
// randomized traffic against a queue-based reference model.
module tb_alu_result_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_c;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_c;
  logic [4:0]  out_flags;
  logic [4:0]  psw;
  logic        ov_sticky;
  logic        clr_sticky;
  logic [2:0]  cond_sel;
  logic        cond_true;
  logic [2:0]  count;

  int tests_run;
  int tests_failed;

  alu_result_buffer #(.WIDTH(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_c       (in_c),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_flags  (out_flags),
    .psw        (psw),
    .ov_sticky  (ov_sticky),
    .clr_sticky (clr_sticky),
    .cond_sel   (cond_sel),
    .cond_true  (cond_true),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push(input logic [15:0] c, input logic [4:0] f);
    in_valid = 1'b1;
    in_c     = c;
    in_flags = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [15:0] exp_c);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_c"}, 32'(out_c), 32'(exp_c));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [4:0] flags;
    logic [2:0] sel;
    logic       exp;
  } vec_t;

  vec_t vecs[10];

  // Reference model state
  typedef struct {
    logic [15:0] c;
    logic [4:0]  f;
  } entry_t;

  entry_t      mq[$];
  logic [4:0]  m_psw;
  logic        m_sticky;

  logic [15:0] exp_seq[$];
  logic [15:0] vals3[3];
  logic [15:0] vals5[5];

  function automatic logic cond_ref(input logic [4:0] f, input logic [2:0] sel);
    case (sel)
      3'd0: return 1'b1;
      3'd1: return f[3];
      3'd2: return !f[3];
      3'd3: return f[4];
      3'd4: return !f[4];
      3'd5: return f[1];
      3'd6: return f[0];
      default: return f[2];
    endcase
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_c       = '0;
    in_flags   = '0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    cond_sel   = 3'd0;

    vecs[0] = '{5'b01000, 3'd1, 1'b1};
    vecs[1] = '{5'b01000, 3'd2, 1'b0};
    vecs[2] = '{5'b00000, 3'd2, 1'b1};
    vecs[3] = '{5'b10000, 3'd3, 1'b1};
    vecs[4] = '{5'b10000, 3'd4, 1'b0};
    vecs[5] = '{5'b00010, 3'd5, 1'b1};
    vecs[6] = '{5'b00001, 3'd6, 1'b1};
    vecs[7] = '{5'b11110, 3'd6, 1'b0};
    vecs[8] = '{5'b00000, 3'd0, 1'b1};
    vecs[9] = '{5'b11011, 3'd7, 1'b0};

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_psw", 32'(psw), 32'd0);
    check("rst_sticky", 32'(ov_sticky), 32'd0);
    check("rst_out_c", 32'(out_c), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, then condition checks on psw
    push(16'h3896, 5'b00100);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_c", 32'(out_c), 32'h3896);
    check("single_flags", 32'(out_flags), 32'b00100);
    check("single_psw", 32'(psw), 32'b00100);
    cond_sel = 3'd7;
    #1;
    check("single_cond7", 32'(cond_true), 32'd1);
    cond_sel = 3'd1;
    #1;
    check("single_cond1", 32'(cond_true), 32'd0);
    pop_check("single_pop", 16'h3896);
    check("single_empty", 32'(count), 32'd0);

    // Three pushes then ordered pops
    vals3[0] = 16'h0125; vals3[1] = 16'h2723; vals3[2] = 16'h2400;
    for (int i = 0; i < 3; i++) push(vals3[i], 5'(i));
    check("three_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) pop_check("three_pop", vals3[i]);
    check("three_count_end", 32'(count), 32'd0);
    check("three_valid_end", 32'(out_valid), 32'd0);

    // Overfill: 5th push dropped
    for (int i = 0; i < 5; i++) vals5[i] = 16'hA000 + 16'(i);
    for (int i = 0; i < 5; i++) begin
      push(vals5[i], 5'b00000);
      if (i == 3) check("full_in_ready", 32'(in_ready), 32'd0);
    end
    check("full_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) pop_check("full_pop", vals5[i]);
    check("full_drained", 32'(out_valid), 32'd0);
    check("full_count_end", 32'(count), 32'd0);

    // Steady push+pop at count=2 across pointer wrap
    exp_seq.delete();
    for (int i = 0; i < 2; i++) begin
      push(16'h1000 + 16'(i), 5'b00000);
      exp_seq.push_back(16'h1000 + 16'(i));
    end
    for (int i = 2; i < 12; i++) begin
      check("stream_head", 32'(out_c), 32'(exp_seq[0]));
      in_valid  = 1'b1;
      in_c      = 16'h1000 + 16'(i);
      in_flags  = 5'b00000;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      void'(exp_seq.pop_front());
      exp_seq.push_back(16'h1000 + 16'(i));
      check("stream_count", 32'(count), 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    while (exp_seq.size() > 0) pop_check("stream_drain", exp_seq.pop_front());

    // Sticky overflow: set beats clear, then clear alone
    clr_sticky = 1'b1;
    push(16'h0001, 5'b00001);
    check("sticky_set", 32'(ov_sticky), 32'd1);
    push(16'h0002, 5'b00000);
    check("sticky_clr", 32'(ov_sticky), 32'd0);
    clr_sticky = 1'b0;
    check("sticky_psw", 32'(psw), 32'd0);
    cond_sel = 3'd2;
    #1;
    check("sticky_cond2", 32'(cond_true), 32'd1);
    pop_check("sticky_pop0", 16'h0001);
    pop_check("sticky_pop1", 16'h0002);

    // Condition table
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b1;
      push(16'h5000 + 16'(i), vecs[i].flags);
      out_ready = 1'b0;
      check("table_psw", 32'(psw), 32'(vecs[i].flags));
      cond_sel = vecs[i].sel;
      #1;
      check("table_cond", 32'(cond_true), 32'(vecs[i].exp));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("table_drained", 32'(count), 32'd0);

    // Randomized traffic against the queue model
    mq.delete();
    m_psw    = psw;
    m_sticky = ov_sticky;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic do_push, do_pop;
      in_valid   = ($urandom_range(0, 99) < 60);
      out_ready  = ($urandom_range(0, 99) < 50);
      clr_sticky = ($urandom_range(0, 99) < 10);
      in_c       = 16'($urandom);
      in_flags   = 5'($urandom);
      cond_sel   = 3'($urandom);
      #1;
      check("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("rnd_in_ready", 32'(in_ready), 32'(mq.size() < 4));
      check("rnd_count", 32'(count), 32'(mq.size()));
      check("rnd_psw", 32'(psw), 32'(m_psw));
      check("rnd_sticky", 32'(ov_sticky), 32'(m_sticky));
      check("rnd_cond", 32'(cond_true), 32'(cond_ref(m_psw, cond_sel)));
      if (mq.size() > 0) begin
        check("rnd_out_c", 32'(out_c), 32'(mq[0].c));
        check("rnd_out_flags", 32'(out_flags), 32'(mq[0].f));
      end
      do_push = in_valid && (mq.size() < 4);
      do_pop  = out_ready && (mq.size() > 0);
      @(posedge clk);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{in_c, in_flags});
        m_psw = in_flags;
      end
      if (do_push && in_flags[0]) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
      #1;
    end
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;

    // Mid-stream asynchronous reset
    while (count != 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(16'h7700 + 16'(i), 5'b11111);
    check("midrst_pre_count", 32'(count), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_psw", 32'(psw), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_sticky", 32'(ov_sticky), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 16-bit ALU. Captures each ALU result C and its five flags (S, Z, P, Cout, Ov) through a valid/ready handshake.
- Buffers results in a DEPTH-entry FIFO for the writeback consumer.
- Maintains a program status word (PSW) of the most recently accepted flags, a sticky overflow bit, and a condition evaluator for the branch logic.

Parameters:
- WIDTH, 16, data width of C.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result present.
- in_ready  out  1  buffer can accept; equals not full.
- in_c  in  WIDTH  ALU result C.
- in_flags  in  5  {S,Z,P,Cout,Ov}, bit4 = S down to bit0 = Ov.
- out_valid  out  1  head entry valid; equals not empty.
- out_ready  in  1  consumer takes the head.
- out_c  out  WIDTH  head result.
- out_flags  out  5  head flags, same ordering as in_flags.
- psw  out  5  flags of the last accepted result.
- ov_sticky  out  1  set by any accepted Ov=1.
- clr_sticky  in  1  synchronous clear of ov_sticky.
- cond_sel  in  3  condition select.
- cond_true  out  1  selected condition evaluated on psw.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset, asynchronous on rst_n low:
  - Read pointer, write pointer, count, psw and ov_sticky all cleared to 0.
  - out_valid = 0 and in_ready = 1 while in reset.
  - out_c and out_flags read 0 when empty after reset; storage contents are not reset.
- Push = in_valid & in_ready. On push, {in_c, in_flags} is written at the write pointer, which then increments modulo DEPTH.
- Pop = out_valid & out_ready. On pop, the read pointer increments modulo DEPTH.
- out_c and out_flags are driven combinationally from the head entry (the read pointer).
- Latency: a result pushed into an empty buffer at edge N appears with out_valid = 1 after edge N, so the consumer can take it at edge N+1.
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged; both pointers advance.
- Full (count = DEPTH): in_ready = 0 and in_valid is ignored. A pop frees a slot, and in_ready rises the cycle after the pop edge; there is no same-cycle fall-through.
- Empty: out_valid = 0 and out_ready is ignored. There is no input-to-output bypass.
- Pointers wrap from DEPTH-1 to 0. Full and empty are decided by count, not by pointer equality.
- psw loads in_flags on every push, registered. Pops do not change psw.
- ov_sticky:
  - Set on a push with in_flags[0] = 1.
  - Cleared when clr_sticky = 1.
  - If set and clear occur in the same cycle, set wins.
- cond_true is combinational from psw and cond_sel:
  - 0 = always 1
  - 1 = Z
  - 2 = not Z
  - 3 = S
  - 4 = not S
  - 5 = Cout
  - 6 = Ov
  - 7 = P
- Reset in mid-operation flushes all entries. Partially completed handshakes are discarded.
- The block does not interpret flags; it only stores and passes them through unchanged.

Decomposition:
- Shared package alu_pkg holds:
  - Flag bit index constants: FLG_S=4, FLG_Z=3, FLG_P=2, FLG_C=1, FLG_OV=0.
  - Condition-select encodings: COND_ALWAYS through COND_P.
  - ALU_WIDTH = 16.
- One sub-module, alu_cond_eval: combinational mapping of psw and cond_sel to cond_true, reused by the branch unit.
- FIFO storage and control stay in alu_result_buffer.

Test Plan:
- Reset, then a single push of in_c=16'h3896, flags=5'b00100 -> out_valid=1 the next cycle with out_c=16'h3896; psw=5'b00100; cond_sel=7 gives cond_true=1; cond_sel=1 gives cond_true=0.
- Push 16'h0125, 16'h2723 and 16'h2400 with out_ready=0 -> count=3; popping yields them in that order; count returns to 0 and out_valid=0.
- Push 5 entries with out_ready=0 -> in_ready=0 after the 4th push; the 5th value is dropped; the pop sequence contains only the first 4 values.
- Hold the buffer at count=2 and push and pop together for 10 cycles -> count stays 2; data stays in order across pointer wrap.
- Push flags=5'b00001 while clr_sticky=1 -> ov_sticky=1. Next cycle push flags=0 with clr_sticky=1 -> ov_sticky=0. psw=0 and cond_sel=2 gives cond_true=1.
- Assert rst_n=0 mid-stream with count=3 -> out_valid=0, count=0, psw=0 and in_ready=1 immediately, without waiting for a clock edge.
